// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg : shared widths, fetch defaults and fetch-state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [XLEN-1:0] IMEM_BYTES_DEF = 32'd1024;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_next_pc.sv
// ---------------------------------------------------------------------------
// fetch_next_pc : next fetch-address select and fetch-fault check
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_next_pc
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [XLEN-1:0] IMEM_BYTES = IMEM_BYTES_DEF
) (
  input  logic [1:0]      state_i,
  input  logic [XLEN-1:0] out_pc_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] issue_addr_o,
  output logic            fault_o,
  output logic [XLEN-1:0] fault_addr_o
);

  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            check;

  always_comb begin
    target       = {redirect_pc_i[XLEN-1:2], 2'b00};
    misaligned   = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    check        = 1'b0;
    issue_addr_o = out_pc_i;
    if (state_i == S_BOOT) begin
      issue_addr_o = RESET_PC;
    end else if (redirect_i) begin
      issue_addr_o = target;
      check        = 1'b1;
    end else if ((state_i == S_RUN) && !stall_i) begin
      // Wraps mod 2^32; only addresses not already known in range are checked.
      issue_addr_o = out_pc_i + 32'd4;
      check        = 1'b1;
    end
    fault_o      = check && (misaligned || (issue_addr_o >= IMEM_BYTES));
    fault_addr_o = misaligned ? redirect_pc_i : issue_addr_o;
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch : fetch initiator for a 1-cycle-latency synchronous imem
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [XLEN-1:0] IMEM_BYTES = IMEM_BYTES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o,
  output logic            fault_o,
  output logic [XLEN-1:0] fault_pc_o,
  output logic [XLEN-1:0] fetch_cnt_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            out_vld_q, out_vld_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] issue_addr;
  logic            nxt_fault;
  logic [XLEN-1:0] nxt_fault_addr;
  logic            accept;

  fetch_next_pc #(
    .RESET_PC   (RESET_PC),
    .IMEM_BYTES (IMEM_BYTES)
  ) u_next_pc (
    .state_i       (state_q),
    .out_pc_i      (out_pc_q),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .issue_addr_o  (issue_addr),
    .fault_o       (nxt_fault),
    .fault_addr_o  (nxt_fault_addr)
  );

  // Outputs are forced to their reset view while rst is high, even mid-run.
  assign imem_addr   = rst ? RESET_PC : issue_addr;
  assign instr_o     = imem_rdata;
  assign pc_o        = rst ? RESET_PC : out_pc_q;
  assign valid_o     = !rst && out_vld_q && (state_q == S_RUN);
  assign fault_o     = !rst && (state_q == S_FAULT);
  assign fault_pc_o  = fault_pc_q;
  assign fetch_cnt_o = cnt_q;

  // A redirect kills the presented word: it is on the wrong path.
  assign accept = valid_o && !stall_i && !redirect_i;

  always_comb begin
    state_d    = state_q;
    out_pc_d   = out_pc_q;
    out_vld_d  = out_vld_q;
    fault_pc_d = fault_pc_q;
    cnt_d      = accept ? cnt_q + 32'd1 : cnt_q;
    case (state_q)
      S_BOOT: begin
        state_d   = S_RUN;
        out_pc_d  = RESET_PC;
        out_vld_d = 1'b1;
      end
      S_RUN: begin
        if (nxt_fault) begin
          state_d    = S_FAULT;
          out_vld_d  = 1'b0;
          fault_pc_d = nxt_fault_addr;
        end else if (redirect_i || !stall_i) begin
          out_pc_d  = issue_addr;
          out_vld_d = 1'b1;
        end
      end
      S_FAULT: begin
        if (redirect_i) begin
          if (nxt_fault) begin
            fault_pc_d = nxt_fault_addr;
          end else begin
            state_d   = S_RUN;
            out_pc_d  = issue_addr;
            out_vld_d = 1'b1;
          end
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      out_pc_q   <= RESET_PC;
      out_vld_q  <= 1'b0;
      fault_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_pc_q   <= out_pc_d;
      out_vld_q  <= out_vld_d;
      fault_pc_q <= fault_pc_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch : directed plus randomized bench with a behavioural model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] IMEM_BYTES = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        fault_o;
  logic [31:0] fault_pc_o;
  logic [31:0] fetch_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];

  instr_fetch #(
    .RESET_PC   (RESET_PC),
    .IMEM_BYTES (IMEM_BYTES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .fault_o       (fault_o),
    .fault_pc_o    (fault_pc_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: one-cycle read latency, word 0 in reset.
  always @(posedge clk) imem_rdata <= rst ? mem[0] : mem[imem_addr[9:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = booting, 1 = fetching, 2 = halted on fault.
  bit          m_init = 1'b0;
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_fpc;
  logic [31:0] m_cnt;

  function automatic bit bad_target(input logic [31:0] raw);
    logic [31:0] al;
    al = raw & 32'hFFFF_FFFC;
    return (raw[1:0] != 2'b00) || (al >= IMEM_BYTES);
  endfunction

  always @(posedge clk) begin
    logic [31:0] al;
    logic [31:0] nxt;
    al = redirect_pc & 32'hFFFF_FFFC;
    if (rst) begin
      m_init  = 1'b1;
      m_phase = 0;
      m_pc    = RESET_PC;
      m_fpc   = 32'h0;
      m_cnt   = 32'h0;
    end else if (m_init) begin
      if (m_phase == 0) begin
        m_phase = 1;
        m_pc    = RESET_PC;
      end else if (m_phase == 1) begin
        if (!stall && !redirect) m_cnt = m_cnt + 1;
        if (redirect) begin
          if (bad_target(redirect_pc)) begin
            m_phase = 2;
            m_fpc   = (redirect_pc[1:0] != 2'b00) ? redirect_pc : al;
          end else begin
            m_pc = al;
          end
        end else if (!stall) begin
          nxt = m_pc + 4;
          if (nxt >= IMEM_BYTES) begin
            m_phase = 2;
            m_fpc   = nxt;
          end else begin
            m_pc = nxt;
          end
        end
      end else if (redirect) begin
        if (bad_target(redirect_pc)) begin
          m_fpc = (redirect_pc[1:0] != 2'b00) ? redirect_pc : al;
        end else begin
          m_phase = 1;
          m_pc    = al;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_addr;
    if (m_init) begin
      if (rst) begin
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_fault", fault_o, 1'b0);
        chk("rst_pc", pc_o, RESET_PC);
        chk("rst_addr", imem_addr, RESET_PC);
      end else if (m_phase == 0) begin
        chk("boot_valid", valid_o, 1'b0);
        chk("boot_fault", fault_o, 1'b0);
        chk("boot_addr", imem_addr, RESET_PC);
        chk("boot_pc", pc_o, m_pc);
      end else if (m_phase == 1) begin
        if (redirect)   exp_addr = redirect_pc & 32'hFFFF_FFFC;
        else if (stall) exp_addr = m_pc;
        else            exp_addr = m_pc + 4;
        chk("run_valid", valid_o, 1'b1);
        chk("run_fault", fault_o, 1'b0);
        chk("run_pc", pc_o, m_pc);
        chk("run_instr", instr_o, mem[m_pc[9:2]]);
        chk("run_addr", imem_addr, exp_addr);
      end else begin
        chk("flt_valid", valid_o, 1'b0);
        chk("flt_fault", fault_o, 1'b1);
        if (redirect) chk("flt_addr", imem_addr, redirect_pc & 32'hFFFF_FFFC);
      end
      chk("fault_pc", fault_pc_o, m_fpc);
      chk("count", fetch_cnt_o, m_cnt);
    end
  end

  task automatic drive(input bit r, input bit s, input bit rd, input logic [31:0] rp);
    @(posedge clk);
    #1;
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rp;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] tgt;
    int          pick;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) drive(1, 0, 0, 0);

    // Boot and sequential fetch
    drive(0, 0, 0, 0);
    chk("d_boot_valid", valid_o, 1'b0);
    drive(0, 0, 0, 0);
    chk("d_first_valid", valid_o, 1'b1);
    chk("d_first_instr", instr_o, 32'h1000_0000);
    chk("d_first_pc", pc_o, 32'h0);
    drive(0, 0, 0, 0);
    chk("d_pc4", pc_o, 32'h4);
    chk("d_cnt1", fetch_cnt_o, 32'd1);

    // Three-cycle stall at 0x8
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0);
      chk("d_stall_addr", imem_addr, 32'h8);
      chk("d_stall_pc", pc_o, 32'h8);
      chk("d_stall_instr", instr_o, 32'h1000_0002);
      chk("d_stall_cnt", fetch_cnt_o, 32'd2);
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("d_after_stall_pc", pc_o, 32'hC);

    // Redirect at 0x10 kills that word
    drive(0, 0, 1, 32'h40);
    chk("d_redir_from", pc_o, 32'h10);
    drive(0, 1, 1, 32'h80);
    chk("d_redir_pc", pc_o, 32'h40);
    chk("d_redir_cnt", fetch_cnt_o, 32'd4);
    drive(0, 0, 1, 32'h42);
    chk("d_rs_pc", pc_o, 32'h80);

    // Misaligned redirect faults; stall ignored; aligned redirect recovers
    drive(0, 1, 0, 0);
    chk("d_mis_fault", fault_o, 1'b1);
    chk("d_mis_fpc", fault_pc_o, 32'h42);
    chk("d_mis_valid", valid_o, 1'b0);
    drive(0, 0, 1, 32'h20);
    drive(0, 0, 1, 32'h3F0);
    chk("d_recover_pc", pc_o, 32'h20);
    chk("d_recover_valid", valid_o, 1'b1);

    // Run off the end of memory, then reset mid-fault
    repeat (4) drive(0, 0, 0, 0);
    chk("d_last_pc", pc_o, 32'h3FC);
    chk("d_last_addr", imem_addr, 32'h400);
    drive(0, 0, 0, 0);
    chk("d_oor_fault", fault_o, 1'b1);
    chk("d_oor_fpc", fault_pc_o, 32'h400);
    chk("d_oor_cnt", fetch_cnt_o, 32'd8);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("d_rst_cnt", fetch_cnt_o, 32'd0);
    chk("d_rst_fpc", fault_pc_o, 32'd0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("d_restart_pc", pc_o, RESET_PC);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      pick = $urandom_range(99);
      if ($urandom_range(199) == 0) begin
        drive(1, 0, 0, 0);
      end else if (pick < 15) begin
        pick = $urandom_range(9);
        if (pick == 0)      tgt = ($urandom_range(255) << 2) | $urandom_range(1, 3);
        else if (pick == 1) tgt = 32'h400 + ($urandom_range(1023) << 2);
        else if (pick == 2) tgt = 32'h3F0 + ($urandom_range(3) << 2);
        else                tgt = $urandom_range(255) << 2;
        drive(0, $urandom_range(1) == 1, 1, tgt);
      end else begin
        drive(0, pick < 40, 0, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch-side initiator for the single-cycle-latency synchronous instruction memory. The memory registers the word at `addrIn[9:2]` on each rising edge; while reset is high it returns word 0.
- Drives the fetch address, tracks which PC each returned word belongs to, and presents instruction/PC/valid to decode.
- Handles decode stalls by re-fetching the same word, applies branch redirects, flags fetch faults and counts accepted instructions.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
- IMEM_BYTES, 1024, size of the instruction memory in bytes (256 words); addresses at or above this fault.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- imem_addr  out  32  fetch address to memory `addrIn`; combinational, always word-aligned
- imem_rdata  in  32  memory `instrOut`; word for the address issued on the previous cycle
- stall_i  in  1  decode cannot accept this cycle
- redirect_i  in  1  branch/jump taken; overrides sequential flow
- redirect_pc_i  in  32  redirect target
- instr_o  out  32  instruction to decode (equals `imem_rdata`)
- pc_o  out  32  PC of `instr_o`
- valid_o  out  1  `instr_o`/`pc_o` are meaningful
- fault_o  out  1  fetch fault latched; fetch halted
- fault_pc_o  out  32  offending address (misaligned target or out-of-range PC)
- fetch_cnt_o  out  32  accepted-instruction count

Behaviour:
- Registers:
  - `out_pc_q`: address issued last cycle.
  - `out_vld_q`: that word is on the correct path.
  - `state_q` ∈ {S_BOOT, S_RUN, S_FAULT}.
  - `fault_pc_q`.
  - `cnt_q`.
- Reset (`rst`=1, any state, mid-operation included):
  - state=S_BOOT, `out_pc_q`=RESET_PC, `out_vld_q`=0, `cnt_q`=0, `fault_pc_q`=0.
  - Outputs: `valid_o`=0, `fault_o`=0, `pc_o`=RESET_PC, `imem_addr`=RESET_PC.
- Outputs:
  - `instr_o`=`imem_rdata`.
  - `pc_o`=`out_pc_q`.
  - `valid_o`=`out_vld_q` & (state==S_RUN).
  - `fault_o`=(state==S_FAULT).
  - `fetch_cnt_o`=`cnt_q`.
- Accept = `valid_o` & !`stall_i` & !`redirect_i`.
  - A redirect kills the presented (younger, wrong-path) instruction even when not stalled.
  - `cnt_q` increments on accept and wraps modulo 2^32.
- S_BOOT (first cycle after reset release):
  - `imem_addr`=RESET_PC.
  - Next: `out_pc_q`=RESET_PC, `out_vld_q`=1, go to S_RUN.
  - First `valid_o`=1 is the 2nd cycle after `rst` falls.
  - `redirect_i`/`stall_i` are ignored in S_BOOT.
- S_RUN next-address priority:
  1. `redirect_i`: target={`redirect_pc_i`[31:2],2'b00}.
     - Misaligned if `redirect_pc_i`[1:0]≠0.
     - `imem_addr`=target, `out_pc_q`←target, `out_vld_q`←1.
  2. `stall_i` (no redirect): `imem_addr`=`out_pc_q`, so the memory re-reads the same word. `out_pc_q`/`out_vld_q` hold.
     - Instruction, PC and valid stay stable for the whole stall.
  3. Otherwise: `imem_addr`=`out_pc_q`+4, computed mod 2^32 (0xFFFF_FFFC wraps to 0). `out_pc_q`←`imem_addr`, `out_vld_q`←1.
- Fault detection, S_RUN:
  - Triggers: the chosen issue address is ≥ IMEM_BYTES, or the redirect is misaligned.
  - Action: go to S_FAULT, `out_vld_q`←0, `fault_pc_q`←offending address.
  - For misalignment, `fault_pc_q` holds the raw `redirect_pc_i`.
  - An instruction presented in the same cycle is still accepted normally if the accept rule holds.
- S_FAULT:
  - `imem_addr`=`out_pc_q`, `valid_o`=0, `stall_i` ignored.
  - Exit only on `redirect_i` to an aligned, in-range target. Same actions as S_RUN redirect, then go to S_RUN.
  - A faulting redirect stays in S_FAULT and updates `fault_pc_q`.
- Redirect latency: redirect in cycle t → target instruction `valid_o`=1 in cycle t+1.
- Simultaneous redirect+stall: redirect wins.

Decomposition:
- Shared package `rv_pkg`:
  - XLEN=32, RESET_PC default, IMEM_BYTES default.
  - Fetch-state encoding typedef (S_BOOT=0, S_RUN=1, S_FAULT=2).
  - Instruction-word width constant.
- Optional sub-module `fetch_next_pc`: combinational next-address select plus fault check. Everything else stays in `instr_fetch`.

Test Plan:
1. Reset release, no stall, memory loaded with word i = 0x1000_0000+i. Required:
   - `valid_o` first high on cycle 2.
   - `pc_o` = 0, 4, 8, … each cycle; `instr_o` = 0x1000_0000, 0x1000_0001, ….
   - `fetch_cnt_o` increments every cycle.
2. Stall 3 cycles while `pc_o`=0x8. Required:
   - `imem_addr`=0x8 throughout; `instr_o`/`pc_o` stable; count frozen.
   - Cycle after stall drops: `pc_o`=0xC.
3. Redirect to 0x40 while `pc_o`=0x10, no stall. Required:
   - Instruction at 0x10 not counted.
   - Next cycle `pc_o`=0x40, `valid_o`=1.
4. Redirect+stall in the same cycle (target 0x80). Required: redirect wins; next `pc_o`=0x80.
5. Redirect to 0x42. Required:
   - S_FAULT, `fault_o`=1, `fault_pc_o`=0x42, `valid_o`=0.
   - Stall ignored.
   - Redirect to 0x20 → `valid_o`=1, `pc_o`=0x20 the next cycle.
6. Sequential run reaching 0x3FC, then assert `rst` mid-stream. Required:
   - Next issue 0x400 → `fault_o`=1, `fault_pc_o`=0x400.
   - `rst` clears the fault and the count; fetch restarts at RESET_PC.
